interp_phase_commutator: RTL and testbench

//  Downstream of the polyphase comb branches (E0..E7) in the Tx interpolation chain.

---
 rtl/interp_phase_commutator_pkg.sv | 19 +
 rtl/interp_phase_commutator_round_sat.sv | 38 +++
 rtl/interp_phase_commutator.sv | 162 ++++++++++++++++
 tb/tb_interp_phase_commutator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_phase_commutator_pkg.sv
// Shared defaults and types for the polyphase output commutator.
//   NUM_PH_D : polyphase branches (interpolation factor)
//   IN_W_D   : signed width of each branch output
//   OUT_W_D  : signed width of the serialized DAC-path sample
//   SHIFT_D  : gain-normalization right shift applied after rounding
//   state_t  : commutator FSM states
package interp_phase_commutator_pkg;

  localparam int unsigned NUM_PH_D = 8;
  localparam int unsigned IN_W_D   = 20;
  localparam int unsigned OUT_W_D  = 10;
  localparam int unsigned SHIFT_D  = 9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/interp_phase_commutator_round_sat.sv
// interp_round_sat: combinational round-half-up, arithmetic right shift and
// saturation of one branch sample to the output width.
//   x    : signed IN_W input sample
//   y    : signed OUT_W rounded/shifted/clipped result
//   clip : high when the shifted value fell outside the OUT_W range
module interp_round_sat #(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = 10,
  parameter int unsigned SHIFT = 9
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    clip
);

  localparam logic signed [IN_W:0] RND  = (IN_W+1)'(2**(SHIFT-1));
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2**(OUT_W-1)-1);
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  logic signed [IN_W:0] w_r;
  logic signed [IN_W:0] w_s;

  always_comb begin
    // one guard bit keeps x + half-LSB from overflowing
    w_r  = {x[IN_W-1], x} + RND;
    w_s  = w_r >>> SHIFT;
    clip = 1'b0;
    y    = w_s[OUT_W-1:0];
    if (w_s > MAXV) begin
      y    = MAXV[OUT_W-1:0];
      clip = 1'b1;
    end else if (w_s < MINV) begin
      y    = MINV[OUT_W-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/interp_phase_commutator.sv
// interp_phase_commutator: accepts one frame of NUM_PH parallel polyphase
// branch outputs and serializes it, phase 0 first, into rounded/saturated
// high-rate samples. Active buffer A is serialized while pending buffer P
// holds the next frame, so back-to-back frames stream without bubbles.
//   clk, rst   : clock, synchronous active-high reset
//   in_phases  : packed branches, phase k at [k*IN_W +: IN_W]
//   in_valid   : frame valid;  in_ready : frame accepted when both high
//   out_data   : serialized sample; out_valid/out_ready : sample handshake
//   out_first  : marks the phase-0 sample of each frame
//   sat_flag   : sticky clip indicator; sat_clr clears it (clip wins)
module interp_phase_commutator
  import interp_phase_commutator_pkg::*;
#(
  parameter int unsigned NUM_PH = NUM_PH_D,
  parameter int unsigned IN_W   = IN_W_D,
  parameter int unsigned OUT_W  = OUT_W_D,
  parameter int unsigned SHIFT  = SHIFT_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PH*IN_W-1:0] in_phases,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_first,
  output logic                   sat_flag,
  input  logic                   sat_clr
);

  localparam int unsigned IDX_W = (NUM_PH > 1) ? $clog2(NUM_PH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PH-1);

  state_t                 r_state, w_state_nxt;
  logic [NUM_PH*IN_W-1:0] r_a, r_p;
  logic                   r_p_full;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [OUT_W-1:0]       r_out_data;
  logic                   r_out_valid, r_out_first, r_sat;

  logic                   w_accept, w_can_adv, w_last;
  logic                   w_emit, w_bypass, w_load_a, w_load_p, w_move_p;
  logic [IN_W-1:0]        w_sel;
  logic [OUT_W-1:0]       w_y;
  logic                   w_clip;

  assign in_ready  = !r_p_full && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_can_adv = !r_out_valid || out_ready;
  assign w_last    = (r_idx == LAST);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_nxt = RUN;
      RUN:  if (w_can_adv && w_last && !r_p_full && !w_accept) w_state_nxt = IDLE;
    endcase
  end

  // control outputs
  always_comb begin
    w_emit    = 1'b0;
    w_bypass  = 1'b0;
    w_load_a  = 1'b0;
    w_load_p  = 1'b0;
    w_move_p  = 1'b0;
    w_idx_nxt = r_idx;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load_a = 1'b1;
          // phase 0 goes straight from the input to the output register so
          // an idle accept produces a sample on the next cycle
          if (w_can_adv) begin
            w_emit    = 1'b1;
            w_bypass  = 1'b1;
            w_idx_nxt = IDX_W'(1);
          end else begin
            w_idx_nxt = '0;
          end
        end
      end
      RUN: begin
        if (w_can_adv) begin
          w_emit = 1'b1;
          if (w_last) begin
            w_idx_nxt = '0;
            if (r_p_full)      w_move_p = 1'b1;
            else if (w_accept) w_load_a = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        // accepting while A is still busy parks the frame in P
        if (w_accept && !(w_can_adv && w_last)) w_load_p = 1'b1;
      end
    endcase
  end

  assign w_sel = w_bypass ? in_phases[IN_W-1:0] : r_a[r_idx*IN_W +: IN_W];

  interp_round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .x    (w_sel),
    .y    (w_y),
    .clip (w_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_p         <= '0;
      r_p_full    <= 1'b0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      if (w_load_a)      r_a <= in_phases;
      else if (w_move_p) r_a <= r_p;

      if (w_load_p) begin
        r_p      <= in_phases;
        r_p_full <= 1'b1;
      end else if (w_move_p) begin
        r_p_full <= 1'b0;
      end

      r_idx <= w_idx_nxt;

      if (w_emit) begin
        r_out_data  <= w_y;
        r_out_valid <= 1'b1;
        r_out_first <= w_bypass || (r_idx == '0);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_first <= 1'b0;
      end

      if (w_emit && w_clip) r_sat <= 1'b1;
      else if (sat_clr)     r_sat <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign sat_flag  = r_sat;

endmodule

// File: tb/tb_interp_phase_commutator.sv
module tb_interp_phase_commutator;

  localparam int NP = 8;
  localparam int IW = 20;
  localparam int OW = 10;

  logic              clk = 1'b0;
  logic              rst, in_valid, out_ready, sat_clr;
  logic [NP*IW-1:0]  in_phases;
  logic              in_ready, out_valid, out_first, sat_flag;
  logic [OW-1:0]     out_data;

  always #5 clk = ~clk;

  interp_phase_commutator #(
    .NUM_PH (NP),
    .IN_W   (IW),
    .OUT_W  (OW),
    .SHIFT  (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_phases (in_phases),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  typedef struct {
    int data;
    bit first;
    bit clip;
  } smp_t;

  smp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   seen_clip = 1'b0;
  bit   track_sat = 1'b0;

  task automatic chk(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // round-half-up of x/512 by floor division, then clip to 10-bit signed
  function automatic int ref_proc(int x, output bit c);
    int r, s;
    r = x + 256;
    if (r >= 0) s = r / 512;
    else        s = -((-r + 511) / 512);
    c = 1'b0;
    if (s > 511)  begin s = 511;  c = 1'b1; end
    if (s < -512) begin s = -512; c = 1'b1; end
    return s;
  endfunction

  function automatic int rnd_val();
    case ($urandom_range(0, 3))
      0:       return int'($urandom) >>> 12;
      1:       return ($urandom_range(0, 1) == 0) ? 524287 : -524288;
      default: return int'($urandom) >>> 16;
    endcase
  endfunction

  task automatic set_frame(input int fr[NP]);
    for (int k = 0; k < NP; k++) in_phases[k*IW +: IW] = IW'(fr[k]);
  endtask

  task automatic set_rand_frame();
    for (int k = 0; k < NP; k++) in_phases[k*IW +: IW] = IW'(rnd_val());
  endtask

  // one clock: settle handshakes into the model, advance, then check holds/sat
  task automatic tick();
    bit acc, hs, hold, pf;
    int pd;
    acc  = in_valid && in_ready;
    hs   = out_valid && out_ready;
    hold = out_valid && !out_ready && !rst;
    pd   = $signed(out_data);
    pf   = out_first;
    if (hs) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        smp_t e;
        e = q.pop_front();
        chk("data", $signed(out_data), e.data);
        chk("first", out_first, e.first);
      end
    end
    if (acc) begin
      for (int k = 0; k < NP; k++) begin
        smp_t s;
        bit   c;
        s.data  = ref_proc($signed(in_phases[k*IW +: IW]), c);
        s.clip  = c;
        s.first = (k == 0);
        q.push_back(s);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      seen_clip = 1'b0;
    end
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", $signed(out_data), pd);
      chk("hold_first", out_first, pf);
    end
    if (track_sat && out_valid && q.size() > 0 && q[0].clip) seen_clip = 1'b1;
    if (track_sat) chk("sat_track", sat_flag, seen_clip);
  endtask

  task automatic drain();
    bit done;
    done      = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      done = (q.size() == 0) && !out_valid;
    end
    chk("drain_done", done, 1);
  endtask

  initial begin
    int fr[NP];
    int exp1[NP];
    int hold_exp;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0; in_phases = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // rounding frame
    fr   = '{512, 256, 255, -256, -257, 0, 1023, -512};
    exp1 = '{1, 1, 0, 0, -1, 0, 2, -1};
    set_frame(fr);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < NP; k++) begin
      chk("round_valid", out_valid, 1);
      chk("round_data", $signed(out_data), exp1[k]);
      chk("round_first", out_first, (k == 0) ? 1 : 0);
      tick();
    end
    chk("round_idle_valid", out_valid, 0);
    chk("round_no_sat", sat_flag, 0);

    // saturation and sticky clear
    fr = '{524287, -524288, 0, 0, 0, 0, 0, 0};
    set_frame(fr);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sat_pos", $signed(out_data), 511);
    chk("sat_set", sat_flag, 1);
    tick();
    chk("sat_neg", $signed(out_data), -512);
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_cleared", sat_flag, 0);
    drain();
    // clip registered in the same cycle as a clear keeps the flag set
    sat_clr = 1'b1;
    fr = '{524287, 0, 0, 0, 0, 0, 0, 0};
    set_frame(fr);
    in_valid = 1'b1;
    tick();
    sat_clr  = 1'b0;
    in_valid = 1'b0;
    chk("clip_beats_clr", sat_flag, 1);
    drain();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;

    // streaming: one frame every NP cycles, no gaps
    for (int f = 0; f < 4; f++) begin
      set_rand_frame();
      in_valid = 1'b1;
      chk("stream_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("stream_valid", out_valid, 1);
      for (int c = 0; c < NP - 1; c++) begin
        tick();
        chk("stream_valid", out_valid, 1);
      end
    end
    drain();

    // backpressure at idx 3 with a second frame parked in P
    set_rand_frame();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b0;
    hold_exp  = q[0].data;
    chk("bp_phase3", $signed(out_data), hold_exp);
    set_rand_frame();
    in_valid = 1'b1;
    chk("bp_accept2", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_hold", $signed(out_data), hold_exp);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    chk("bp_hold", $signed(out_data), hold_exp);
    drain();

    // reset mid-frame with P full
    set_rand_frame();
    in_valid = 1'b1;
    tick();
    set_rand_frame();
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rst_p_full", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready_low", in_ready, 0);
    tick();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_first", out_first, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_in_ready", in_ready, 1);
    set_rand_frame();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_new_first", out_first, 1);
    chk("rst_new_valid", out_valid, 1);
    drain();

    // accept on the idx=7 emit cycle
    set_rand_frame();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    set_rand_frame();
    in_valid = 1'b1;
    chk("last_accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("last_phase7_first", out_first, 0);
    tick();
    chk("last_next_first", out_first, 1);
    chk("last_next_valid", out_valid, 1);
    drain();

    // randomized traffic against the scoreboard
    sat_clr = 1'b1;
    tick();
    sat_clr   = 1'b0;
    seen_clip = 1'b0;
    track_sat = 1'b1;
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_rand_frame();
      tick();
    end
    drain();
    track_sat = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
